// File: rtl/cselect_ws.sv
// Chip-select generator: decodes addr[DEC_HI:DEC_LO] to one active-low select, applies per-region waits, ext_wait and timeout.
// Latency: cs_n at cycle 1, ready at ws+2 (+ ext_wait cycles); err at cycle 1 for unmapped. RELEASE holds off a new access until cs_ is seen high.
module cselect_ws #(
  parameter int ADDR_W  = 32,
  parameter int DEC_HI  = 31,
  parameter int DEC_LO  = 22,
  parameter int NUM_CS  = 8,
  parameter int WS_W    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     cs_,
  input  logic [NUM_CS*WS_W-1:0]   ws_cfg,
  input  logic                     ext_wait,
  output logic [NUM_CS-1:0]        cs_n,
  output logic                     ready,
  output logic                     err,
  output logic                     busy
);

  localparam int IDX_W  = DEC_HI - DEC_LO + 1;
  localparam int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int TCNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
  localparam logic [TCNT_W-1:0] TLAST = (TIMEOUT > 0) ? TCNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR, S_REL} state_t;

  state_t            st;
  logic [SEL_W-1:0]  sel;
  logic [WS_W-1:0]   wcnt;
  logic [TCNT_W-1:0] tcnt;

  logic [IDX_W-1:0]  dec_idx;
  logic [SEL_W-1:0]  dec_sel;
  logic              in_range;
  logic [WS_W-1:0]   ws_sel;
  logic              unused_addr;

  always_comb begin
    dec_idx  = addr[DEC_HI:DEC_LO];
    dec_sel  = dec_idx[SEL_W-1:0];
    in_range = (32'(dec_idx) < NUM_CS);
    ws_sel   = ws_cfg[dec_sel*WS_W +: WS_W];
  end

  // Only the decode field matters; the rest of the address is the device's business.
  assign unused_addr = ^addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= S_IDLE;
      sel   <= '0;
      wcnt  <= '0;
      tcnt  <= '0;
      cs_n  <= '1;
      ready <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (st)
        S_IDLE: begin
          if (!cs_) begin
            busy <= 1'b1;
            if (in_range) begin
              sel  <= dec_sel;
              wcnt <= ws_sel;
              tcnt <= '0;
              cs_n <= ~(NUM_CS'(1) << dec_sel);
              st   <= S_WAIT;
            end else begin
              err <= 1'b1;
              st  <= S_ERR;
            end
          end
        end
        S_WAIT: begin
          if (cs_) begin
            cs_n <= '1;
            busy <= 1'b0;
            st   <= S_IDLE;
          end else if (wcnt != '0) begin
            wcnt <= wcnt - 1'b1;
          end else if (!ext_wait) begin
            ready <= 1'b1;
            st    <= S_DONE;
          end else if (TIMEOUT != 0 && tcnt == TLAST) begin
            err  <= 1'b1;
            cs_n <= '1;
            st   <= S_ERR;
          end else if (TIMEOUT != 0) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE: begin
          cs_n <= '1;
          st   <= S_REL;
        end
        S_ERR: begin
          cs_n <= '1;
          st   <= S_REL;
        end
        S_REL: begin
          // A request still held low must be released before the next access.
          if (cs_) begin
            busy <= 1'b0;
            st   <= S_IDLE;
          end
        end
        default: begin
          cs_n <= '1;
          busy <= 1'b0;
          st   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cselect_ws.sv
// Directed bench for cselect_ws: per-cycle expected {cs_n,ready,err,busy} queued as stimulus is driven, popped and checked each cycle.
module tb_cselect_ws;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        cs_;
  logic [31:0] ws_cfg;
  logic        ext_wait;
  logic [7:0]  cs_n;
  logic        ready;
  logic        err;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic [10:0] v;
  } exp_t;
  exp_t sbq[$];

  cselect_ws #(
    .ADDR_W(32), .DEC_HI(31), .DEC_LO(22), .NUM_CS(8), .WS_W(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .cs_(cs_), .ws_cfg(ws_cfg), .ext_wait(ext_wait),
    .cs_n(cs_n), .ready(ready), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Queue the expected outputs of the next cycle, advance one clock, then compare.
  task automatic tick(input logic [7:0] c, input logic r, input logic e, input logic b, input string tag);
    exp_t x;
    x.tag = tag;
    x.v   = {c, r, e, b};
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    compared++;
    assert ({cs_n, ready, err, busy} === x.v)
      else begin
        mismatched++;
        $error("FAIL %s: observed cs_n/ready/err/busy=%h required=%h", x.tag, {cs_n, ready, err, busy}, x.v);
      end
  endtask

  // Mapped access with ws base waits, n_ext cycles of ext_wait after them, and cs_ held low for hold extra cycles after DONE.
  task automatic access(input int idx, input int ws, input int n_ext, input int hold, input string tag);
    logic [7:0] sel;
    sel = ~(8'd1 << idx);
    ws_cfg[idx*4 +: 4] = 4'(ws);
    addr     = (32'(idx) << 22) | 32'($urandom_range(0, 32'h003F_FFFF));
    cs_      = 1'b0;
    ext_wait = 1'b0;
    for (int k = 1; k <= ws + 1 + n_ext; k++) begin
      tick(sel, 1'b0, 1'b0, 1'b1, tag);
      if (k == 1) begin
        addr   = $urandom;
        ws_cfg = $urandom;
      end
      ext_wait = (k <= ws + n_ext);
    end
    tick(sel, 1'b1, 1'b0, 1'b1, tag);
    ext_wait = 1'b0;
    for (int h = 0; h < hold; h++) tick(8'hFF, 1'b0, 1'b0, 1'b1, tag);
    cs_ = 1'b1;
    if (hold == 0) tick(8'hFF, 1'b0, 1'b0, 1'b1, tag);
    tick(8'hFF, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    rst      = 1'b1;
    cs_      = 1'b1;
    addr     = '0;
    ws_cfg   = '0;
    ext_wait = 1'b0;
    tick(8'hFF, 1'b0, 1'b0, 1'b0, "reset");
    tick(8'hFF, 1'b0, 1'b0, 1'b0, "reset");
    rst = 1'b0;
    tick(8'hFF, 1'b0, 1'b0, 1'b0, "idle");

    access(2, 0, 0, 0, "idx2_ws0");
    access(5, 3, 0, 0, "idx5_ws3");
    access(0, 1, 4, 0, "idx0_ext");
    access(7, 15, 2, 0, "idx7_ws15");
    access(3, 2, TIMEOUT - 1, 0, "ext_max_no_timeout");

    // Timeout: ext_wait never drops, err after TIMEOUT waiting cycles.
    ws_cfg[1*4 +: 4] = 4'd0;
    addr     = 32'h0040_1234;
    cs_      = 1'b0;
    ext_wait = 1'b1;
    for (int k = 1; k <= TIMEOUT; k++) tick(8'hFD, 1'b0, 1'b0, 1'b1, "timeout_wait");
    tick(8'hFF, 1'b0, 1'b1, 1'b1, "timeout_err");
    tick(8'hFF, 1'b0, 1'b0, 1'b1, "timeout_rel");
    tick(8'hFF, 1'b0, 1'b0, 1'b1, "timeout_rel");
    cs_      = 1'b1;
    ext_wait = 1'b0;
    tick(8'hFF, 1'b0, 1'b0, 1'b0, "timeout_idle");

    // Unmapped regions: smallest (8) and largest (1023) index.
    addr = 32'h0200_0000;
    cs_  = 1'b0;
    tick(8'hFF, 1'b0, 1'b1, 1'b1, "unmapped8_err");
    cs_ = 1'b1;
    tick(8'hFF, 1'b0, 1'b0, 1'b1, "unmapped8_rel");
    tick(8'hFF, 1'b0, 1'b0, 1'b0, "unmapped8_idle");
    addr = 32'hFFC0_0000;
    cs_  = 1'b0;
    tick(8'hFF, 1'b0, 1'b1, 1'b1, "unmapped1023_err");
    tick(8'hFF, 1'b0, 1'b0, 1'b1, "unmapped1023_rel");
    cs_ = 1'b1;
    tick(8'hFF, 1'b0, 1'b0, 1'b0, "unmapped1023_idle");

    // Abort: cs_ released in cycle 2 of a ws=5 access.
    ws_cfg[4*4 +: 4] = 4'd5;
    addr = 32'h0100_0000;
    cs_  = 1'b0;
    tick(8'hEF, 1'b0, 1'b0, 1'b1, "abort_wait");
    tick(8'hEF, 1'b0, 1'b0, 1'b1, "abort_wait");
    cs_ = 1'b1;
    tick(8'hFF, 1'b0, 1'b0, 1'b0, "abort_idle");
    tick(8'hFF, 1'b0, 1'b0, 1'b0, "abort_idle");

    // Reset in cycle 3 of a ws=7 access.
    ws_cfg[6*4 +: 4] = 4'd7;
    addr = 32'h0180_0000;
    cs_  = 1'b0;
    for (int k = 1; k <= 3; k++) tick(8'hBF, 1'b0, 1'b0, 1'b1, "rst_wait");
    rst = 1'b1;
    tick(8'hFF, 1'b0, 1'b0, 1'b0, "rst_mid");
    rst = 1'b0;
    cs_ = 1'b1;
    tick(8'hFF, 1'b0, 1'b0, 1'b0, "rst_idle");
    access(6, 7, 0, 0, "after_rst");

    // Request held low across DONE: one ready, no second access.
    access(4, 1, 0, 4, "hold_low");
    access(2, 0, 0, 0, "back_to_back");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
